// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freeze;
    logic pc_sel_branch;
  } ctrl_t;

  // Control patterns, field order as in ctrl_t.
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register observation signals and stall/flush controls.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  import hazard_pkg::*;

  logic                 IDEX_MEMREAD;
  logic [REG_IDX_W-1:0] IDEX_RD;
  logic [REG_IDX_W-1:0] IFID_RN;
  logic [REG_IDX_W-1:0] IFID_RM;
  logic                 IFID_USES_RM;
  logic                 EXMEM_BRANCH_ZERO;
  logic                 EXMEM_ZERO;
  logic                 EXMEM_MEMREQ;
  logic                 MEM_READY;

  logic                 PC_WRITE;
  logic                 IFID_WRITE;
  logic                 IDEX_BUBBLE;
  logic                 IFID_FLUSH;
  logic                 IDEX_FLUSH;
  logic                 PIPE_FREEZE;
  logic                 PC_SEL_BRANCH;
  logic [1:0]           STATE;

  modport master (
    output IDEX_MEMREAD, IDEX_RD, IFID_RN, IFID_RM, IFID_USES_RM,
           EXMEM_BRANCH_ZERO, EXMEM_ZERO, EXMEM_MEMREQ, MEM_READY,
    input  PC_WRITE, IFID_WRITE, IDEX_BUBBLE, IFID_FLUSH, IDEX_FLUSH,
           PIPE_FREEZE, PC_SEL_BRANCH, STATE
  );

  modport slave (
    input  IDEX_MEMREAD, IDEX_RD, IFID_RN, IFID_RM, IFID_USES_RM,
           EXMEM_BRANCH_ZERO, EXMEM_ZERO, EXMEM_MEMREQ, MEM_READY,
    output PC_WRITE, IFID_WRITE, IDEX_BUBBLE, IFID_FLUSH, IDEX_FLUSH,
           PIPE_FREEZE, PC_SEL_BRANCH, STATE
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use dependency check between the EX load and the ID instruction.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter logic [REG_IDX_W-1:0] ZERO_REG = hazard_pkg::XZR_IDX
) (
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rd_i,
  input  logic [REG_IDX_W-1:0] ifid_rn_i,
  input  logic [REG_IDX_W-1:0] ifid_rm_i,
  input  logic                 ifid_uses_rm_i,
  output logic                 lu_hazard_o
);

  logic rn_match;
  logic rm_match;

  assign rn_match = (idex_rd_i == ifid_rn_i);
  // RM only matters when the instruction really reads it (R-type, stores).
  assign rm_match = ifid_uses_rm_i & (idex_rd_i == ifid_rm_i);

  assign lu_hazard_o = idex_memread_i & (idex_rd_i != ZERO_REG) & (rn_match | rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, taken-CBZ squash
// and data-memory freeze. Define HAZARD_PERF_EN to add stall/flush/wait event counters.
module pipe_hazard_ctrl #(
  parameter int                 LOAD_STALL_CYCLES = 1,
  parameter int                 FLUSH_CYCLES      = 2,
  parameter logic [4:0]         XZR_IDX           = hazard_pkg::XZR_IDX
) (
  input  logic                  CLK,
  input  logic                  RESET,
  pipe_hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           STALL_CNT,
  output logic [31:0]           FLUSH_CNT,
  output logic [31:0]           WAIT_CNT
`endif
);
  import hazard_pkg::*;

  localparam logic [CNT_W-1:0] FLUSH_CNT_INIT =
    (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] STALL_CNT_INIT =
    (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_busy;
  logic br_taken;
  logic lu_hazard;

  ctrl_t            run_ctrl;
  state_t           run_state;
  logic [CNT_W-1:0] run_cnt;
  ctrl_t            ctrl;

  assign mem_busy = hz.EXMEM_MEMREQ & ~hz.MEM_READY;
  assign br_taken = hz.EXMEM_BRANCH_ZERO & hz.EXMEM_ZERO;

  hazard_detect #(
    .ZERO_REG (XZR_IDX)
  ) u_detect (
    .idex_memread_i (hz.IDEX_MEMREAD),
    .idex_rd_i      (hz.IDEX_RD),
    .ifid_rn_i      (hz.IFID_RN),
    .ifid_rm_i      (hz.IFID_RM),
    .ifid_uses_rm_i (hz.IFID_USES_RM),
    .lu_hazard_o    (lu_hazard)
  );

  // Decision taken from RUN; also reused by the other states when a higher-priority event wins.
  always_comb begin
    run_ctrl  = CTRL_RUN;
    run_state = ST_RUN;
    run_cnt   = '0;
    if (mem_busy) begin
      run_ctrl  = CTRL_FREEZE;
      run_state = ST_MEM_WAIT;
    end else if (br_taken) begin
      run_ctrl = CTRL_BRANCH;
      if (FLUSH_CYCLES > 1) begin
        run_state = ST_FLUSH;
        run_cnt   = FLUSH_CNT_INIT;
      end
    end else if (lu_hazard) begin
      run_ctrl = CTRL_STALL;
      if (LOAD_STALL_CYCLES > 1) begin
        run_state = ST_LU_STALL;
        run_cnt   = STALL_CNT_INIT;
      end
    end
  end

  always_comb begin
    ctrl    = run_ctrl;
    state_d = run_state;
    cnt_d   = run_cnt;
    case (state_q)
      ST_LU_STALL: begin
        if (!mem_busy && !br_taken) begin
          ctrl = CTRL_STALL;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_LU_STALL;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // A load-use hazard behind a squashed slot is meaningless, so only flush here.
        if (!mem_busy && !br_taken) begin
          ctrl = CTRL_FLUSH;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (!RESET) begin
      ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.PC_WRITE      = ctrl.pc_write;
  assign hz.IFID_WRITE    = ctrl.ifid_write;
  assign hz.IDEX_BUBBLE   = ctrl.idex_bubble;
  assign hz.IFID_FLUSH    = ctrl.ifid_flush;
  assign hz.IDEX_FLUSH    = ctrl.idex_flush;
  assign hz.PIPE_FREEZE   = ctrl.pipe_freeze;
  assign hz.PC_SEL_BRANCH = ctrl.pc_sel_branch;
  assign hz.STATE         = state_q;

`ifdef HAZARD_PERF_EN
  logic [2:0]  perf_evt;
  logic [31:0] perf_q [3];

  assign perf_evt = {ctrl.pipe_freeze, ctrl.ifid_flush, ctrl.idex_bubble};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    always_ff @(posedge CLK) begin
      if (!RESET) begin
        perf_q[gi] <= '0;
      end else if (perf_evt[gi]) begin
        perf_q[gi] <= perf_q[gi] + 32'd1;
      end
    end
  end

  assign STALL_CNT = perf_q[0];
  assign FLUSH_CNT = perf_q[1];
  assign WAIT_CNT  = perf_q[2];
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;

  // Expected control vectors: {PC_WRITE, IFID_WRITE, IDEX_BUBBLE, IFID_FLUSH, IDEX_FLUSH, PIPE_FREEZE, PC_SEL_BRANCH}
  localparam logic [6:0] E_RUN    = 7'b1100000;
  localparam logic [6:0] E_STALL  = 7'b0010000;
  localparam logic [6:0] E_BRANCH = 7'b1101101;
  localparam logic [6:0] E_FLUSH  = 7'b1101100;
  localparam logic [6:0] E_FREEZE = 7'b0000010;
  localparam logic [6:0] E_RESET  = 7'b0001100;

  typedef struct {
    int         id;
    logic [6:0] ctrl;
    logic [1:0] st;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   vec_id;

  pipe_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  pipe_hazard_ctrl dut (
    .CLK   (clk),
    .RESET (rst_n),
    .hz    (hz)
`ifdef HAZARD_PERF_EN
    ,
    .STALL_CNT (stall_cnt),
    .FLUSH_CNT (flush_cnt),
    .WAIT_CNT  (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic memread, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm, input logic uses_rm,
                       input logic bz, input logic zero, input logic req, input logic rdy);
    rst_n                = rst;
    hz.IDEX_MEMREAD      = memread;
    hz.IDEX_RD           = rd;
    hz.IFID_RN           = rn;
    hz.IFID_RM           = rm;
    hz.IFID_USES_RM      = uses_rm;
    hz.EXMEM_BRANCH_ZERO = bz;
    hz.EXMEM_ZERO        = zero;
    hz.EXMEM_MEMREQ      = req;
    hz.MEM_READY         = rdy;
  endtask

  // One clocked vector: apply inputs just after the edge and queue the expected response.
  task automatic step(input logic rst, input logic memread, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic uses_rm,
                      input logic bz, input logic zero, input logic req, input logic rdy,
                      input logic [6:0] e_ctrl, input logic [1:0] e_st);
    exp_t e;
    @(posedge clk);
    #1;
    drive(rst, memread, rd, rn, rm, uses_rm, bz, zero, req, rdy);
    e.id   = vec_id;
    e.ctrl = e_ctrl;
    e.st   = e_st;
    exp_q.push_back(e);
    vec_id++;
  endtask

  task automatic idle(input logic [6:0] e_ctrl, input logic [1:0] e_st);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_ctrl, e_st);
  endtask

  // Monitor: the controller answers every cycle, so one queued expectation is checked per negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = exp_q.pop_front();
      got = {hz.PC_WRITE, hz.IFID_WRITE, hz.IDEX_BUBBLE, hz.IFID_FLUSH,
             hz.IDEX_FLUSH, hz.PIPE_FREEZE, hz.PC_SEL_BRANCH};
      n_total++;
      if (got === e.ctrl) begin
        n_pass++;
        $display("vec%0d ctrl ok %b state %0d", e.id, got, hz.STATE);
      end else begin
        $display("FAIL vec%0d ctrl: got %b expected %b", e.id, got, e.ctrl);
      end
      n_total++;
      if (hz.STATE === e.st) begin
        n_pass++;
      end else begin
        $display("FAIL vec%0d state: got %0d expected %0d", e.id, hz.STATE, e.st);
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vec_id  = 0;
    drive(1'b0, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    //   rst  mrd  rd     rn     rm     urm   bz    z     req   rdy   expected  state
    step(1'b0, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RESET, 2'd0);
    idle(E_RUN, 2'd0);
    // LDUR X2 ; ADD X3,X2,X4
    step(1'b1, 1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL, 2'd0);
    idle(E_RUN, 2'd0);
    step(1'b1, 1'b1, 5'd31, 5'd31, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, 2'd0);
    step(1'b1, 1'b1, 5'd2, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, 2'd0);
    step(1'b1, 1'b1, 5'd2, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL, 2'd0);
    step(1'b1, 1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, 2'd0);
    // Taken CBZ: branch cycle then one more flush cycle
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_BRANCH, 2'd0);
    idle(E_FLUSH, 2'd2);
    idle(E_RUN, 2'd0);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN, 2'd0);
    // Memory wait: three busy cycles then release
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE, 2'd0);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE, 2'd3);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE, 2'd3);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN, 2'd3);
    idle(E_RUN, 2'd0);
    // Branch and load-use together: flush wins, hazard ignored while flushing
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_BRANCH, 2'd0);
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_FLUSH, 2'd2);
    idle(E_RUN, 2'd0);
    // Busy memory with a taken branch behind it: freeze, then branch on the ready cycle
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_FREEZE, 2'd0);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_FREEZE, 2'd3);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, E_BRANCH, 2'd3);
    idle(E_FLUSH, 2'd2);
    idle(E_RUN, 2'd0);
    // Busy memory with a load-use hazard: freeze first, stall on the ready cycle
    step(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE, 2'd0);
    step(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_STALL, 2'd3);
    idle(E_RUN, 2'd0);
    // Reset in the middle of a flush abandons it
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_BRANCH, 2'd0);
    step(1'b0, 1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RESET, 2'd2);
    idle(E_RUN, 2'd0);
    idle(E_RUN, 2'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline. It watches the ID/EX and EX/MEM pipeline register contents and the data-memory handshake, and drives write-enable, bubble and flush controls to the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three hazards: load-use (bubble insertion), taken CBZ branch (younger-stage squash), and data-memory wait (whole-pipe freeze). It sits beside the pipeline registers; all its outputs are consumed in the same cycle by those registers.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 2, cycles IF/ID and ID/EX are squashed after a taken branch (1..3)
XZR_IDX, 31, register index that never creates a dependency

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-low reset
IDEX_MEMREAD  in  1  instruction in EX is a load
IDEX_RD  in  5  destination register of the instruction in EX
IFID_RN  in  5  first source register of the instruction in ID
IFID_RM  in  5  second source register of the instruction in ID
IFID_USES_RM  in  1  ID instruction actually reads RM (stores, R-type)
EXMEM_BRANCH_ZERO  in  1  MEM-stage instruction is CBZ
EXMEM_ZERO  in  1  ALU zero flag held in EX/MEM
EXMEM_MEMREQ  in  1  MEM-stage load or store active
MEM_READY  in  1  data memory completes the access this cycle
PC_WRITE  out  1  PC may update
IFID_WRITE  out  1  IF/ID may load
IDEX_BUBBLE  out  1  load zeros into ID/EX control fields
IFID_FLUSH  out  1  clear IF/ID to NOP
IDEX_FLUSH  out  1  clear ID/EX control fields
PIPE_FREEZE  out  1  hold ID/EX, EX/MEM and MEM/WB
PC_SEL_BRANCH  out  1  select branch target for PC
STATE  out  2  current FSM state, debug

Behaviour:
- FSM states: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3. Single 3-bit counter CNT shared by LU_STALL and FLUSH.
- Derived: mem_busy = EXMEM_MEMREQ & ~MEM_READY; br_taken = EXMEM_BRANCH_ZERO & EXMEM_ZERO; lu_hazard = IDEX_MEMREAD & IDEX_RD!=XZR_IDX & (IDEX_RD==IFID_RN | (IFID_USES_RM & IDEX_RD==IFID_RM)).
- Priority in every state: mem_busy > br_taken > lu_hazard.
- Outputs are combinational from state and inputs; state and CNT are registered.
- RUN: defaults PC_WRITE=1, IFID_WRITE=1, others 0.
  - mem_busy: PIPE_FREEZE=1, PC_WRITE=0, IFID_WRITE=0; next MEM_WAIT.
  - br_taken: PC_SEL_BRANCH=1, IFID_FLUSH=1, IDEX_FLUSH=1; if FLUSH_CYCLES>1, next FLUSH with CNT=FLUSH_CYCLES-2, else stay in RUN.
  - lu_hazard: PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1; if LOAD_STALL_CYCLES>1, next LU_STALL with CNT=LOAD_STALL_CYCLES-2, else stay in RUN.
- LU_STALL: same outputs as lu_hazard. When CNT==0, return to RUN, else decrement CNT. A br_taken arriving here aborts the stall (flush behaviour, go to FLUSH/RUN). A mem_busy arriving here goes to MEM_WAIT; the remaining stall is discarded because the hazard is re-detected on exit.
- FLUSH: IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1, PC_SEL_BRANCH=0. When CNT==0, return to RUN, else decrement CNT. lu_hazard is ignored here.
- MEM_WAIT: PIPE_FREEZE=1, PC_WRITE=0, IFID_WRITE=0, all flush and bubble outputs 0. Stay while mem_busy; when MEM_READY rises, apply the RUN decision in that same cycle. A taken branch held in EX/MEM is therefore acted on exactly once, after the access completes.
- Reset (RESET=0 at a rising edge): state RUN, CNT=0. The outputs during reset are forced to PC_WRITE=0, IFID_WRITE=0, and IFID_FLUSH=IDEX_FLUSH=1, with all others 0. Reset mid-stall or mid-flush abandons the sequence.
- Equality comparisons are 5-bit unsigned. The XZR destination never stalls.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs STALL_CNT[31:0], FLUSH_CNT[31:0] and WAIT_CNT[31:0]. Each increments once per cycle in which IDEX_BUBBLE, IFID_FLUSH or PIPE_FREEZE (respectively) is asserted outside reset. Counters wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds: state encodings (ST_RUN, ST_LU_STALL, ST_FLUSH, ST_MEM_WAIT), REG_IDX_W=5, XZR_IDX=31.
- One sub-module, hazard_detect: purely combinational lu_hazard compare logic, reusable by the forwarding unit.
- FSM and counter stay in the top module.

Test Plan:
- LDUR X2 then ADD X3,X2,X4 (IDEX_RD=2, IFID_RN=2, IDEX_MEMREAD=1) → exactly 1 cycle of PC_WRITE=0, IDEX_BUBBLE=1, then RUN.
- Same hazard with IDEX_RD=31 → no stall. Same hazard with IFID_RM=2 and IFID_USES_RM=0 → no stall.
- CBZ taken (EXMEM_BRANCH_ZERO=1, EXMEM_ZERO=1) with FLUSH_CYCLES=2 → PC_SEL_BRANCH=1 for 1 cycle; IFID_FLUSH and IDEX_FLUSH high for 2 cycles; STATE goes 0→2→0.
- EXMEM_MEMREQ=1 with MEM_READY low for 3 cycles → PIPE_FREEZE=1 for 3 cycles, STATE=3, released in the cycle MEM_READY=1.
- Simultaneous br_taken and lu_hazard → flush only, no IDEX_BUBBLE. Simultaneous mem_busy and br_taken → freeze first, then the flush on the MEM_READY cycle.
- RESET low during FLUSH with CNT=1 → next cycle STATE=0, and the flush does not continue after reset is released.
